data_mem_dump: RTL and testbench
================================

DATA_MEM_DUMP -- requirements
Module: data_mem_dump

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_dump  input  1  one-cycle request to begin a dump.
REQ-005 SHALL have port first_addr  input  8  first data-memory word to dump, sampled on accepted start_dump.
REQ-006 SHALL have port last_addr  input  8  final data-memory word to dump, sampled on accepted start_dump.
REQ-007 SHALL have port mem_addr  output  8  read address to the 256x16 data memory.
REQ-008 SHALL have port mem_read_data  input  16  data memory read data, valid one cycle after mem_addr is presented.
REQ-009 SHALL have port ser_out  output  1  serial dump stream, idle high.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last frame's stop bit.

Function
REQ-012 SHALL implement states IDLE, ADDR, CAPTURE, SEND, DONE.
REQ-013 In IDLE, start_dump=1 SHALL latch first_addr into cur_addr and last_addr into end_addr, then move to ADDR.
REQ-014 ADDR SHALL drive mem_addr=cur_addr for one cycle, then move to CAPTURE.
REQ-015 CAPTURE SHALL load mem_read_data into a 16-bit shift register, then move to SEND.
REQ-016 Latency: start_dump at edge N; mem_addr valid after N+1; data captured at N+2; start bit on ser_out from edge N+3.
REQ-017 Frame SHALL be: start bit 0, 16 data bits LSB first, then stop bit 1, with each bit held exactly CLKS_PER_BIT cycles.
REQ-018 Bit timing SHALL use an 8-bit cycle counter and a 5-bit bit index, both cleared at every frame start.
REQ-019 After the stop bit: if cur_addr==end_addr, go to DONE; otherwise cur_addr SHALL become cur_addr+1 modulo 256 and the state SHALL go to ADDR.
REQ-020 Wrap-around: when last_addr<first_addr, the dump SHALL run from first_addr through 0xFF, then 0x00 through last_addr.
REQ-021 When first_addr==last_addr, the dump SHALL send exactly one frame.
REQ-022 DONE SHALL assert done for one cycle with busy still high, then return to IDLE.
REQ-023 start_dump SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-024 mem_addr SHALL hold cur_addr in all states, so the read address is stable between reads.
REQ-025 ser_out SHALL be 1 in IDLE, ADDR, CAPTURE and DONE, so there is an idle gap of at least 3 cycles between frames.

Reset
REQ-026 Reset SHALL force state=IDLE, ser_out=1, busy=0, done=0, mem_addr=0x00, and counters and shift register to 0.
REQ-027 Reset asserted mid-frame SHALL abort the dump with no further frame bits, and ser_out SHALL be 1 on the next edge.
REQ-028 Reset SHALL take priority over a simultaneous start_dump.

Configuration
REQ-029 Macro DUMP_PARITY_EN defined: an even-parity bit (XOR of the 16 data bits) SHALL be inserted between data bit 15 and the stop bit, for a 19-bit frame.
REQ-030 Macro DUMP_PARITY_EN undefined: no parity logic SHALL be present, and the frame SHALL be 18 bits.

Verification
REQ-031 Single word, CLKS_PER_BIT=4, mem[0x05]=0xA5C3, first=last=0x05: ser_out SHALL be 0 x4, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), then 1 x4; done SHALL pulse 75 cycles after start; mem_addr SHALL be 0x05.
REQ-032 Wrap-around, first=0xFE, last=0x01: mem_addr SHALL sequence 0xFE,0xFF,0x00,0x01, with exactly 4 frames and one done pulse.
REQ-033 start_dump pulsed during SEND with different addresses: the in-progress dump SHALL be unaffected and no extra frames SHALL be sent.
REQ-034 Reset asserted at data bit 7 of the first frame: ser_out=1 and busy=0 on the next edge; a new start_dump afterwards SHALL produce a full correct frame.
REQ-035 With DUMP_PARITY_EN defined, mem=0x0001: parity bit SHALL be 1; with mem=0xA5C3: parity bit SHALL be 0; frame SHALL be 19x4 cycles.

Source files
------------

// File: rtl/data_mem_dump_if.sv
// Bus bundle for data_mem_dump: dump request, data-memory read port and serial status.
interface data_mem_dump_if;
    logic        start_dump;
    logic [7:0]  first_addr;
    logic [7:0]  last_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_read_data;
    logic        ser_out;
    logic        busy;
    logic        done;

    modport slave (
        input  start_dump, first_addr, last_addr, mem_read_data,
        output mem_addr, ser_out, busy, done
    );

    modport master (
        output start_dump, first_addr, last_addr, mem_read_data,
        input  mem_addr, ser_out, busy, done
    );
endinterface

// File: rtl/data_mem_dump.sv
// Dumps a range of 16-bit data-memory words as UART-style frames (LSB first, idle high).
// Optional macro DUMP_PARITY_EN adds an even-parity bit before the stop bit.
module data_mem_dump #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input logic             clk,
    input logic             reset,
    data_mem_dump_if.slave  bus
);

    localparam logic [7:0] CntMax = 8'(CLKS_PER_BIT - 1);
`ifdef DUMP_PARITY_EN
    localparam logic [4:0] StopIdx = 5'd18;
`else
    localparam logic [4:0] StopIdx = 5'd17;
`endif
    // One extra non-timed slot after the stop bit lets the registered ser_out drain it.
    localparam logic [4:0] TailIdx = StopIdx + 5'd1;

    typedef enum logic [2:0] {StIdle, StAddr, StCapture, StSend, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cur_addr_q, cur_addr_d;
    logic [7:0]  end_addr_q, end_addr_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        ser_out_q, ser_out_d;
    logic        frame_bit;
`ifdef DUMP_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ser_out_d  = 1'b1;
`ifdef DUMP_PARITY_EN
        parity_d   = parity_q;
`endif

        frame_bit = 1'b1;
        if (idx_q == 5'd0) begin
            frame_bit = 1'b0;
        end else if (idx_q <= 5'd16) begin
            frame_bit = shift_q[0];
`ifdef DUMP_PARITY_EN
        end else if (idx_q == 5'd17) begin
            frame_bit = parity_q;
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start_dump) begin
                    cur_addr_d = bus.first_addr;
                    end_addr_d = bus.last_addr;
                    state_d    = StAddr;
                end
            end
            StAddr: state_d = StCapture;
            StCapture: begin
                shift_d = bus.mem_read_data;
                cnt_d   = 8'd0;
                idx_d   = 5'd0;
`ifdef DUMP_PARITY_EN
                parity_d = ^bus.mem_read_data;
`endif
                state_d = StSend;
            end
            StSend: begin
                if (idx_q == TailIdx) begin
                    if (cur_addr_q == end_addr_q) begin
                        state_d = StDone;
                    end else begin
                        cur_addr_d = cur_addr_q + 8'd1;
                        state_d    = StAddr;
                    end
                end else begin
                    ser_out_d = frame_bit;
                    if (cnt_q == CntMax) begin
                        cnt_d = 8'd0;
                        idx_d = idx_q + 5'd1;
                        if (idx_q != 5'd0 && idx_q <= 5'd16) begin
                            shift_d = shift_q >> 1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cur_addr_q <= 8'd0;
            end_addr_q <= 8'd0;
            shift_q    <= 16'd0;
            cnt_q      <= 8'd0;
            idx_q      <= 5'd0;
            ser_out_q  <= 1'b1;
`ifdef DUMP_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ser_out_q  <= ser_out_d;
`ifdef DUMP_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.mem_addr = cur_addr_q;
    assign bus.ser_out  = ser_out_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_data_mem_dump.sv
// Bench for data_mem_dump: random memory image, directed and random dump ranges, each
// checked cycle by cycle against a frame-list model of the serial stream.
module tb_data_mem_dump;

    localparam int unsigned CPB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] mem [256];
    int          checks   = 0;
    int          failures = 0;

    data_mem_dump_if bus ();

    data_mem_dump #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory.
    always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump(input logic [7:0] first, input logic [7:0] last,
                            input int mid_start_j, input int abort_j, input bit start_in_done);
        logic [7:0]  addrs[$];
        bit          exp_ser[$];
        int          starts[$];
        logic [7:0]  a;
        logic [15:0] d;
        int          total;
        int          k;
        a = first;
        for (int n = 0; n < 256; n++) begin
            addrs.push_back(a);
            if (a == last) break;
            a = a + 8'd1;
        end
        // Expected wire: 3 idle samples, then each frame, 3-cycle gap between frames, done cycle.
        repeat (3) exp_ser.push_back(1'b1);
        for (int f = 0; f < addrs.size(); f++) begin
            d = mem[addrs[f]];
            starts.push_back(exp_ser.size());
            repeat (CPB) exp_ser.push_back(1'b0);
            for (int b = 0; b < 16; b++) repeat (CPB) exp_ser.push_back(d[b]);
`ifdef DUMP_PARITY_EN
            repeat (CPB) exp_ser.push_back(^d);
`endif
            repeat (CPB) exp_ser.push_back(1'b1);
            if (f != addrs.size() - 1) repeat (3) exp_ser.push_back(1'b1);
        end
        exp_ser.push_back(1'b1);
        total = exp_ser.size();

        bus.first_addr = first;
        bus.last_addr  = last;
        bus.start_dump = 1'b1;
        tick();
        bus.start_dump = 1'b0;
        k = 0;
        for (int j = 0; j < total; j++) begin
            chk($sformatf("ser_out %0h-%0h j=%0d", first, last, j), 16'(bus.ser_out),
                16'(exp_ser[j]));
            chk($sformatf("busy j=%0d", j), 16'(bus.busy), 16'd1);
            chk($sformatf("done j=%0d", j), 16'(bus.done), 16'(j == total - 1));
            if (k < starts.size() && j == starts[k]) begin
                chk($sformatf("mem_addr frame %0d", k), 16'(bus.mem_addr), 16'(addrs[k]));
                k++;
            end
            if (j == total - 1) chk("mem_addr at done", 16'(bus.mem_addr), 16'(last));
            if (j == abort_j) begin
                reset = 1'b1;
                tick();
                chk("abort ser_out", 16'(bus.ser_out), 16'd1);
                chk("abort busy", 16'(bus.busy), 16'd0);
                chk("abort done", 16'(bus.done), 16'd0);
                chk("abort mem_addr", 16'(bus.mem_addr), 16'd0);
                reset = 1'b0;
                return;
            end
            if (j == mid_start_j) begin
                bus.first_addr = 8'hAA;
                bus.last_addr  = 8'h20;
            end
            bus.start_dump = (j == mid_start_j) || (start_in_done && j == total - 1);
            tick();
        end
        bus.start_dump = 1'b0;
        chk("after done busy", 16'(bus.busy), 16'd0);
        chk("after done done", 16'(bus.done), 16'd0);
        chk("after done ser_out", 16'(bus.ser_out), 16'd1);
        tick();
        chk("idle stays idle", 16'(bus.busy), 16'd0);
        chk("idle ser_out", 16'(bus.ser_out), 16'd1);
    endtask

    initial begin
        logic [7:0] rf;
        logic [7:0] rl;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h05] = 16'hA5C3;
        mem[8'h10] = 16'h0001;
        reset          = 1'b1;
        bus.start_dump = 1'b0;
        bus.first_addr = 8'h00;
        bus.last_addr  = 8'h00;

        repeat (2) tick();
        chk("reset ser_out", 16'(bus.ser_out), 16'd1);
        chk("reset busy", 16'(bus.busy), 16'd0);
        chk("reset done", 16'(bus.done), 16'd0);
        chk("reset mem_addr", 16'(bus.mem_addr), 16'd0);

        // Reset wins over a simultaneous start.
        bus.first_addr = 8'h05;
        bus.last_addr  = 8'h05;
        bus.start_dump = 1'b1;
        tick();
        chk("reset priority busy", 16'(bus.busy), 16'd0);
        reset          = 1'b0;
        bus.start_dump = 1'b0;
        tick();
        chk("post reset busy", 16'(bus.busy), 16'd0);
        chk("post reset ser_out", 16'(bus.ser_out), 16'd1);

        run_dump(8'h05, 8'h05, -1, -1, 1'b0);
        run_dump(8'hFE, 8'h01, -1, -1, 1'b1);
        run_dump(8'h30, 8'h31, 3 + 5 * CPB, -1, 1'b0);
        run_dump(8'h05, 8'h05, -1, 3 + 8 * CPB + 1, 1'b0);
        run_dump(8'h05, 8'h05, -1, -1, 1'b0);
        run_dump(8'h10, 8'h10, -1, -1, 1'b0);
        repeat (4) begin
            rf = 8'($urandom);
            rl = rf + 8'($urandom_range(0, 2));
            run_dump(rf, rl, -1, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
